// File: rtl/arduino_cmd_rx_if.sv
// Arduino control-link bus: the serial line into the receiver and the
// command/status outputs it drives back to the mode selector.
interface arduino_cmd_rx_if;
    logic       uart_rx;
    logic [7:0] arduino_command;
    logic       cmd_valid;
    logic       frame_err;
    logic       busy;

    // Receiver side: consumes the serial line, drives command and status.
    modport slave (
        input  uart_rx,
        output arduino_command, cmd_valid, frame_err, busy
    );

    // Host side: drives the serial line, observes command and status.
    modport master (
        output uart_rx,
        input  arduino_command, cmd_valid, frame_err, busy
    );
endinterface

// File: rtl/arduino_cmd_rx.sv
// arduino_cmd_rx: 8N1 UART receiver and command latch for the Arduino link.
// Holds the last accepted byte on arduino_command; malformed frames
// (bad stop bit, break) never touch it.
// Optional feature macro: ARDUINO_CMD_DEBOUNCE_EN -- when defined, a byte is
// committed only when it repeats the previously received good byte.
module arduino_cmd_rx #(
    parameter int         CLK_FREQ = 50_000_000,
    parameter int         BAUD     = 115200,
    parameter logic [7:0] IDLE_CMD = 8'h55
) (
    input logic             clk,
    input logic             reset,
    arduino_cmd_rx_if.slave bus
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_ACCEPT,
        S_BREAK
    } state_t;

    logic             r_sync1;
    logic             r_sync2;
    logic             w_rx_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_sh;
    logic [7:0]       r_cmd;
    logic             r_cmd_valid;
    logic             r_frame_err;
    logic             r_busy;
    logic             w_commit;

    assign w_rx_s = r_sync2;

    // Two-flop synchroniser for the asynchronous line; idles high out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.uart_rx;
            r_sync2 <= r_sync1;
        end
    end

`ifdef ARDUINO_CMD_DEBOUNCE_EN
    logic [7:0] r_cand;
    logic       r_cand_ok;

    // Candidate byte: every good frame loads it, a bad stop bit makes the next
    // good frame a fresh candidate rather than a confirmation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cand    <= ~IDLE_CMD;
            r_cand_ok <= 1'b1;
        end else if (r_state == S_ACCEPT) begin
            r_cand    <= r_sh;
            r_cand_ok <= 1'b1;
        end else if (r_state == S_STOP && r_cnt == CNT_FULL && !w_rx_s) begin
            r_cand_ok <= 1'b0;
        end
    end

    assign w_commit = r_cand_ok && (r_cand == r_sh);
`else
    assign w_commit = 1'b1;
`endif

    // Frame state machine with registered command and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_sh        <= '0;
            r_cmd       <= IDLE_CMD;
            r_cmd_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_cnt == CNT_HALF) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state <= S_DATA;
                            r_idx   <= '0;
                        end else begin
                            // Line went back high before mid start bit: glitch.
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (r_cnt == CNT_FULL) begin
                        r_cnt       <= '0;
                        r_sh[r_idx] <= w_rx_s;
                        if (r_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (r_cnt == CNT_FULL) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_state <= S_ACCEPT;
                        end else begin
                            r_state     <= S_BREAK;
                            r_frame_err <= 1'b1;
                            r_sh        <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_ACCEPT: begin
                    // Returning to IDLE mid stop bit lets back-to-back frames through.
                    if (w_commit) begin
                        r_cmd       <= r_sh;
                        r_cmd_valid <= 1'b1;
                    end
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                S_BREAK: begin
                    // A held-low line yields a single frame_err until it releases.
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.arduino_command = r_cmd;
    assign bus.cmd_valid       = r_cmd_valid;
    assign bus.frame_err       = r_frame_err;
    assign bus.busy            = r_busy;
endmodule

// File: tb/tb_arduino_cmd_rx.sv
// Bench for arduino_cmd_rx: directed frames followed by random traffic
// (frames, bad stops, glitches, resets) against a span-based reference model.
module tb_arduino_cmd_rx;
    localparam int         CLK_FREQ = 1_000_000;
    localparam int         BAUD     = 100_000;
    localparam int         C        = CLK_FREQ / BAUD;
    localparam int         H        = C / 2;
    localparam logic [7:0] IDLE_CMD = 8'h55;
    localparam int         N        = 20000;

    logic clk = 1'b0;
    logic reset;

    arduino_cmd_rx_if bus();

    arduino_cmd_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .IDLE_CMD (IDLE_CMD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Stimulus per cycle, model expectations per cycle, captured DUT outputs.
    bit         line_a  [N];
    bit         rst_a   [N];
    bit         e_busy  [N];
    bit         e_valid [N];
    bit         e_ferr  [N];
    logic [7:0] e_cmd   [N];
    logic       g_busy  [N];
    logic       g_valid [N];
    logic       g_ferr  [N];
    logic [7:0] g_cmd   [N];

    int w;
    int checks;
    int errors;

    task automatic put(input bit b, input int len);
        for (int i = 0; i < len; i++) begin
            if (w < N) line_a[w] = b;
            w++;
        end
    endtask

    task automatic put_frame(input logic [7:0] d, input bit stop);
        put(1'b0, C);
        for (int k = 0; k < 8; k++) put(d[k], C);
        put(stop, C);
    endtask

    // Line level the receiver acts on at edge n: two cycles of synchroniser
    // delay, forced high for the two edges after a reset.
    function automatic bit v_at(input int n);
        if (n < 2 || n > N) return 1'b1;
        if (rst_a[n-1] || rst_a[n-2]) return 1'b1;
        return line_a[n-2];
    endfunction

    task automatic build_stimulus();
        logic [7:0] d;
        bit         bad;
        int         kind;
        for (int i = 0; i < N; i++) begin
            line_a[i] = 1'b1;
            rst_a[i]  = 1'b0;
        end
        rst_a[0] = 1'b1; rst_a[1] = 1'b1; rst_a[2] = 1'b1;
        w = 0;
        put(1'b1, 200);                 // idle until 200
        put_frame(8'h00, 1'b1);         // 200..299
        put_frame(8'hFF, 1'b1);         // 300..399, no gap
        put(1'b1, 50);                  // to 450
        put_frame(8'hA5, 1'b0);         // 450..549, bad stop
        put(1'b0, 20);                  // held low to 569
        put(1'b1, 30);                  // to 600
        put_frame(8'h3C, 1'b1);         // 600..699
        put(1'b1, 20);                  // to 720
        put(1'b0, 3);                   // glitch 720..722
        put(1'b1, 37);                  // to 760
        put_frame(8'hFF, 1'b1);         // 760..859, reset in data bit 4
        rst_a[813] = 1'b1;
        put(1'b1, 20);                  // to 880
        put_frame(8'h00, 1'b1);         // 880..979
        put(1'b1, 30);                  // to 1010
        rst_a[1000] = 1'b1;
        put_frame(8'hFF, 1'b1);         // 1010..1109
        put_frame(8'h00, 1'b1);         // 1110..1209
        put_frame(8'h00, 1'b1);         // 1210..1309
        put(1'b1, 10);
        while (w < N - 400) begin
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                put(1'b0, int'($urandom_range(1, 4)));
                put(1'b1, int'($urandom_range(8, 30)));
            end else begin
                d   = 8'($urandom);
                bad = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 14) == 0) rst_a[w + int'($urandom_range(0, 110))] = 1'b1;
                put_frame(d, !bad);
                if (bad) put(1'b0, int'($urandom_range(0, 25)));
                put(1'b1, int'($urandom_range(0, 20)));
            end
        end
    endtask

    // Model: walks the line frame by frame using the bit-centre timing rules
    // and fills the expected output of every cycle.
    task automatic build_model();
        int         n, t0, last, r, m, e, kind;
        logic [7:0] cmd, cand, byte_v;
        bit         cand_ok, commit;
        n = 0; cmd = IDLE_CMD; cand = ~IDLE_CMD; cand_ok = 1'b1;
        e = 0; byte_v = '0;
        for (int i = 0; i < N; i++) begin
            e_busy[i] = 1'b0; e_valid[i] = 1'b0; e_ferr[i] = 1'b0; e_cmd[i] = IDLE_CMD;
        end
        while (n < N) begin
            if (rst_a[n]) begin
                cmd = IDLE_CMD; cand = ~IDLE_CMD; cand_ok = 1'b1;
                e_cmd[n] = cmd;
                n++;
                continue;
            end
            if (v_at(n)) begin
                e_cmd[n] = cmd;
                n++;
                continue;
            end
            t0 = n;
            if (v_at(t0 + H)) begin
                kind = 0; last = t0 + H;
            end else begin
                e = t0 + H + 9 * C;
                for (int k = 0; k < 8; k++) byte_v[k] = v_at(t0 + H + (k + 1) * C);
                if (v_at(e)) begin
                    kind = 1; last = e + 1;
                end else begin
                    kind = 2;
                    m = e + 1;
                    while (!v_at(m)) m++;
                    last = m;
                end
            end
            r = -1;
            for (int x = t0 + 1; x <= last && x < N; x++) begin
                if (rst_a[x]) begin
                    r = x;
                    break;
                end
            end
            if (r >= 0) begin
                for (int x = t0; x < r; x++) begin
                    e_busy[x] = 1'b1; e_cmd[x] = cmd;
                end
                n = r;
                continue;
            end
            for (int x = t0; x < last && x < N; x++) begin
                e_busy[x] = 1'b1; e_cmd[x] = cmd;
            end
            if (kind == 1) begin
`ifdef ARDUINO_CMD_DEBOUNCE_EN
                commit  = cand_ok && (cand == byte_v);
                cand    = byte_v;
                cand_ok = 1'b1;
`else
                commit = 1'b1;
`endif
                if (commit) cmd = byte_v;
                if (last < N) e_valid[last] = commit;
            end else if (kind == 2) begin
                if (e < N) e_ferr[e] = 1'b1;
                cand_ok = 1'b0;
            end
            if (last < N) begin
                e_busy[last] = 1'b0; e_cmd[last] = cmd;
            end
            n = last + 1;
        end
    endtask

    // Hand-computed value at cycle n, checked against both model and DUT.
    // sel: 0 busy, 1 cmd_valid, 2 frame_err, 3 arduino_command.
    task automatic pin(input string nm, input int n, input int sel, input logic [7:0] want);
        logic [7:0] ev, gv;
        case (sel)
            0:       begin ev = {7'b0, e_busy[n]};  gv = {7'b0, g_busy[n]};  end
            1:       begin ev = {7'b0, e_valid[n]}; gv = {7'b0, g_valid[n]}; end
            2:       begin ev = {7'b0, e_ferr[n]};  gv = {7'b0, g_ferr[n]};  end
            default: begin ev = e_cmd[n];           gv = g_cmd[n];           end
        endcase
        checks++;
        if (ev !== want) begin
            errors++;
            $display("FAIL %s model@%0d: got %h want %h", nm, n, ev, want);
        end
        checks++;
        if (gv !== want) begin
            errors++;
            $display("FAIL %s dut@%0d: got %h want %h", nm, n, gv, want);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        build_stimulus();
        build_model();
        reset       = rst_a[0];
        bus.uart_rx = line_a[0];
        for (int n = 0; n < N; n++) begin
            @(posedge clk);
            #1;
            g_busy[n]  = bus.busy;
            g_valid[n] = bus.cmd_valid;
            g_ferr[n]  = bus.frame_err;
            g_cmd[n]   = bus.arduino_command;
            checks++;
            if (bus.busy !== e_busy[n] || bus.cmd_valid !== e_valid[n] ||
                bus.frame_err !== e_ferr[n] || bus.arduino_command !== e_cmd[n]) begin
                errors++;
                $display("FAIL cycle %0d: got busy=%b valid=%b ferr=%b cmd=%h, want busy=%b valid=%b ferr=%b cmd=%h",
                         n, bus.busy, bus.cmd_valid, bus.frame_err, bus.arduino_command,
                         e_busy[n], e_valid[n], e_ferr[n], e_cmd[n]);
            end
            if (n > 0) begin
                checks++;
                if (g_cmd[n] !== g_cmd[n-1] && g_valid[n] !== 1'b1 && !rst_a[n]) begin
                    errors++;
                    $display("FAIL cmd_hold cycle %0d: got cmd %h->%h without cmd_valid, want unchanged",
                             n, g_cmd[n-1], g_cmd[n]);
                end
            end
            if (n + 1 < N) begin
                reset       = rst_a[n+1];
                bus.uart_rx = line_a[n+1];
            end
        end

        for (int n = 3; n < 200; n++) begin
            pin("idle_busy", n, 0, 8'h00);
            pin("idle_valid", n, 1, 8'h00);
            pin("idle_ferr", n, 2, 8'h00);
            pin("idle_cmd", n, 3, IDLE_CMD);
        end
        pin("bad_ferr_early", 546, 2, 8'h00);
        pin("bad_ferr", 547, 2, 8'h01);
        pin("bad_ferr_late", 548, 2, 8'h00);
        pin("bad_no_valid", 548, 1, 8'h00);
        pin("break_busy", 560, 0, 8'h01);
        pin("break_busy_end", 571, 0, 8'h01);
        pin("break_release", 572, 0, 8'h00);
        pin("glitch_busy", 722, 0, 8'h01);
        pin("glitch_busy_end", 726, 0, 8'h01);
        pin("glitch_idle", 727, 0, 8'h00);
        pin("glitch_no_valid", 727, 1, 8'h00);
        pin("rst_busy_before", 812, 0, 8'h01);
        pin("rst_busy", 813, 0, 8'h00);
        pin("rst_cmd", 813, 3, IDLE_CMD);
        pin("rst_no_valid", 858, 1, 8'h00);
`ifdef ARDUINO_CMD_DEBOUNCE_EN
        pin("deb_first", 1108, 1, 8'h00);
        pin("deb_second", 1208, 1, 8'h00);
        pin("deb_cmd_held", 1307, 3, IDLE_CMD);
        pin("deb_third", 1308, 1, 8'h01);
        pin("deb_cmd", 1308, 3, 8'h00);
`else
        pin("b2b_pre", 297, 1, 8'h00);
        pin("b2b_v0", 298, 1, 8'h01);
        pin("b2b_c0", 298, 3, 8'h00);
        pin("b2b_hold", 397, 3, 8'h00);
        pin("b2b_v1", 398, 1, 8'h01);
        pin("b2b_c1", 398, 3, 8'hFF);
        pin("bad_cmd_kept", 560, 3, 8'hFF);
        pin("after_bad_v", 698, 1, 8'h01);
        pin("after_bad_c", 698, 3, 8'h3C);
        pin("rst_cmd_before", 812, 3, 8'h3C);
        pin("post_rst_v", 978, 1, 8'h01);
        pin("post_rst_c", 978, 3, 8'h00);
        pin("seq_ff", 1108, 3, 8'hFF);
        pin("seq_00", 1208, 1, 8'h01);
        pin("seq_00b", 1308, 1, 8'h01);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
